// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - instruction cache controller: read path, miss detect, line load and fill
//
// Purpose: drives the read index/tag ports of a direct-mapped NUM_PORTS-read /
// 1-write instruction cache array from the fetch PCs, returns per-slot hit data,
// issues one instruction-memory line load at a time for the oldest missing slot,
// and writes the returned line through the single write port.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   fetch_en/fetch_pc     per-slot fetch requests (slot 0 oldest)
//   fetch_data/valid      per-slot line data and hit indication
//   cm_rd_*               cache array read ports (idx/tag out, data/valid in)
//   cm_wr_*               cache array fill write port
//   mem_command/addr      line load request (0=NONE, 1=LOAD)
//   mem_response          nonzero = load accepted with this tag
//   mem_data/mem_tag      returned line and its tag (tag 0 = nothing)
//   busy                  controller not idle
//
// Optional feature macro: ICACHE_PREFETCH_EN (next-line prefetch after each demand fill).
module icache_ctrl #(
  parameter int NUM_PORTS    = 3,
  parameter int IDX_BITS     = 5,
  parameter int TAG_BITS     = 8,
  parameter int MEM_TAG_BITS = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                fetch_en,
  input  logic [NUM_PORTS-1:0][31:0]          fetch_pc,
  output logic [NUM_PORTS-1:0][63:0]          fetch_data,
  output logic [NUM_PORTS-1:0]                fetch_valid,
  output logic [NUM_PORTS-1:0][IDX_BITS-1:0]  cm_rd_idx,
  output logic [NUM_PORTS-1:0][TAG_BITS-1:0]  cm_rd_tag,
  input  logic [NUM_PORTS-1:0][63:0]          cm_rd_data,
  input  logic [NUM_PORTS-1:0]                cm_rd_valid,
  output logic                                cm_wr_en,
  output logic [IDX_BITS-1:0]                 cm_wr_idx,
  output logic [TAG_BITS-1:0]                 cm_wr_tag,
  output logic [63:0]                         cm_wr_data,
  output logic [1:0]                          mem_command,
  output logic [31:0]                         mem_addr,
  input  logic [MEM_TAG_BITS-1:0]             mem_response,
  input  logic [63:0]                         mem_data,
  input  logic [MEM_TAG_BITS-1:0]             mem_tag,
  output logic                                busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
`ifdef ICACHE_PREFETCH_EN
  localparam logic [2:0] ST_PF_REQ  = 3'd3;
  localparam logic [2:0] ST_PF_WAIT = 3'd4;
`endif

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  logic [2:0]              state;
  logic [31:0]             req_addr;
  logic [MEM_TAG_BITS-1:0] pend_tag;

  logic                    miss_found;
  logic [31:0]             miss_addr;
  logic                    in_req;
  logic                    in_wait;
  logic                    fill_hit;

  // Read path is pure wiring; the array does the tag compare.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cm_rd_idx[i]  = fetch_pc[i][3 +: IDX_BITS];
      cm_rd_tag[i]  = fetch_pc[i][8 +: TAG_BITS];
      fetch_data[i] = cm_rd_data[i];
    end
  end

  assign fetch_valid = fetch_en & cm_rd_valid;

  // Oldest missing slot wins: scan downward so the lowest index is assigned last.
  always_comb begin
    miss_found = 1'b0;
    miss_addr  = 32'd0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (fetch_en[i] && !cm_rd_valid[i]) begin
        miss_found = 1'b1;
        miss_addr  = {fetch_pc[i][31:3], 3'b000};
      end
    end
  end

`ifdef ICACHE_PREFETCH_EN
  assign in_req  = (state == ST_REQ)  || (state == ST_PF_REQ);
  assign in_wait = (state == ST_WAIT) || (state == ST_PF_WAIT);
`else
  assign in_req  = (state == ST_REQ);
  assign in_wait = (state == ST_WAIT);
`endif

  assign fill_hit = in_wait && (pend_tag != '0) && (mem_tag == pend_tag);

  // Outputs are masked during reset so an abandoned transaction can never
  // write or issue in the reset cycle itself.
  assign mem_command = (!reset && in_req) ? CMD_LOAD : CMD_NONE;
  assign mem_addr    = req_addr;
  assign cm_wr_en    = !reset && fill_hit;
  assign cm_wr_idx   = req_addr[3 +: IDX_BITS];
  assign cm_wr_tag   = req_addr[8 +: TAG_BITS];
  assign cm_wr_data  = mem_data;
  assign busy        = !reset && (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      req_addr <= 32'd0;
      pend_tag <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss_found) begin
            req_addr <= miss_addr;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_response != '0) begin
            pend_tag <= mem_response;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fill_hit) begin
            pend_tag <= '0;
`ifdef ICACHE_PREFETCH_EN
            req_addr <= req_addr + 32'd8;
            state    <= ST_PF_REQ;
`else
            state    <= ST_IDLE;
`endif
          end
        end
`ifdef ICACHE_PREFETCH_EN
        ST_PF_REQ: begin
          if (mem_response != '0) begin
            pend_tag <= mem_response;
            state    <= ST_PF_WAIT;
          end
        end
        ST_PF_WAIT: begin
          if (fill_hit) begin
            pend_tag <= '0;
            state    <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - self-checking bench for icache_ctrl with cache array and memory models
module tb_icache_ctrl;

  logic              clock = 1'b0;
  logic              reset;
  logic [2:0]        fetch_en;
  logic [2:0][31:0]  fetch_pc;
  logic [2:0][63:0]  fetch_data;
  logic [2:0]        fetch_valid;
  logic [2:0][4:0]   cm_rd_idx;
  logic [2:0][7:0]   cm_rd_tag;
  logic [2:0][63:0]  cm_rd_data;
  logic [2:0]        cm_rd_valid;
  logic              cm_wr_en;
  logic [4:0]        cm_wr_idx;
  logic [7:0]        cm_wr_tag;
  logic [63:0]       cm_wr_data;
  logic [1:0]        mem_command;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_response;
  logic [63:0]       mem_data;
  logic [3:0]        mem_tag;
  logic              busy;

  always #5 clock = ~clock;

  icache_ctrl dut (
    .clock(clock), .reset(reset),
    .fetch_en(fetch_en), .fetch_pc(fetch_pc),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .cm_rd_idx(cm_rd_idx), .cm_rd_tag(cm_rd_tag),
    .cm_rd_data(cm_rd_data), .cm_rd_valid(cm_rd_valid),
    .cm_wr_en(cm_wr_en), .cm_wr_idx(cm_wr_idx), .cm_wr_tag(cm_wr_tag), .cm_wr_data(cm_wr_data),
    .mem_command(mem_command), .mem_addr(mem_addr), .mem_response(mem_response),
    .mem_data(mem_data), .mem_tag(mem_tag), .busy(busy)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // cache array contents (environment)
  bit          a_v [32];
  logic [7:0]  a_t [32];
  logic [63:0] a_d [32];

  // transaction-level reference: one outstanding line, accepted tag (0 = not yet)
  bit          m_out = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [3:0]  m_tag = 4'd0;
  bit          m_pf = 1'b0;

  // memory environment return tracking
  bit          ret_pending = 1'b0;
  logic [3:0]  ret_tag = 4'd0;
  int          ret_delay = 0;
  logic [63:0] ret_data = 64'd0;

  // stimulus for the current cycle
  bit          s_rst;
  logic [2:0]  s_en;
  logic [31:0] s_pc [3];
  logic [3:0]  s_resp;
  logic [3:0]  s_tag;
  logic [63:0] s_data;

  // sampled DUT outputs
  logic [1:0]  o_cmd;
  logic [31:0] o_addr;
  logic        o_wr;
  logic [4:0]  o_widx;
  logic [7:0]  o_wtag;
  logic [63:0] o_wdata;
  logic [2:0]  o_fv;
  logic        o_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic bit exp_load();
    return !s_rst && m_out && (m_tag == 4'd0);
  endfunction

  task automatic step();
    logic [2:0]  rdv;
    bit          e_load, e_wr, e_busy, miss;
    logic [31:0] maddr;
    int          idx;
    reset    = s_rst;
    fetch_en = s_en;
    miss  = 1'b0;
    maddr = 32'd0;
    for (int i = 0; i < 3; i++) begin
      idx = int'(s_pc[i][7:3]);
      fetch_pc[i]   = s_pc[i];
      rdv[i]        = a_v[idx] && (a_t[idx] == s_pc[i][15:8]);
      cm_rd_data[i] = a_d[idx];
    end
    for (int i = 2; i >= 0; i--)
      if (s_en[i] && !rdv[i]) begin
        miss  = 1'b1;
        maddr = {s_pc[i][31:3], 3'b000};
      end
    cm_rd_valid  = rdv;
    mem_response = s_resp;
    mem_tag      = s_tag;
    mem_data     = s_data;
    e_load = exp_load();
    e_wr   = !s_rst && m_out && (m_tag != 4'd0) && (s_tag == m_tag);
    e_busy = !s_rst && m_out;
    #4;
    o_cmd = mem_command; o_addr = mem_addr; o_wr = cm_wr_en; o_widx = cm_wr_idx;
    o_wtag = cm_wr_tag; o_wdata = cm_wr_data; o_fv = fetch_valid; o_busy = busy;
    chk("mem_command", o_cmd, e_load ? 64'd1 : 64'd0);
    chk("busy", o_busy, e_busy);
    chk("cm_wr_en", o_wr, e_wr);
    if (e_load) chk("mem_addr", o_addr, m_addr);
    if (e_wr) begin
      chk("cm_wr_idx", o_widx, m_addr[7:3]);
      chk("cm_wr_tag", o_wtag, m_addr[15:8]);
      chk("cm_wr_data", o_wdata, s_data);
    end
    chk("fetch_valid", o_fv, s_en & rdv);
    for (int i = 0; i < 3; i++) begin
      chk("cm_rd_idx", cm_rd_idx[i], s_pc[i][7:3]);
      chk("cm_rd_tag", cm_rd_tag[i], s_pc[i][15:8]);
      chk("fetch_data", fetch_data[i], a_d[int'(s_pc[i][7:3])]);
    end
    @(posedge clock);
    // memory environment
    if (ret_pending && ret_delay == 0 && s_tag == ret_tag) ret_pending = 1'b0;
    else if (ret_pending && ret_delay > 0) ret_delay--;
    if (e_load && s_resp != 4'd0) begin
      ret_pending = 1'b1;
      ret_tag     = s_resp;
      ret_delay   = $urandom_range(0, 5);
      ret_data    = {$urandom(), $urandom()};
    end
    // reference model
    if (s_rst) begin
      m_out = 1'b0; m_tag = 4'd0; m_pf = 1'b0;
    end else if (m_out) begin
      if (m_tag == 4'd0) begin
        if (s_resp != 4'd0) m_tag = s_resp;
      end else if (s_tag == m_tag) begin
        idx = int'(m_addr[7:3]);
        a_v[idx] = 1'b1; a_t[idx] = m_addr[15:8]; a_d[idx] = s_data;
        m_tag = 4'd0;
`ifdef ICACHE_PREFETCH_EN
        if (!m_pf) begin
          m_pf = 1'b1; m_addr = m_addr + 32'd8;
        end else m_out = 1'b0;
`else
        m_out = 1'b0;
`endif
      end
    end else if (miss) begin
      m_out = 1'b1; m_addr = maddr; m_tag = 4'd0; m_pf = 1'b0;
    end
    #1;
  endtask

  task automatic set_d(input bit rst, input logic [2:0] en, input logic [31:0] p0,
                       input logic [31:0] p1, input logic [31:0] p2,
                       input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] data);
    s_rst = rst; s_en = en; s_pc[0] = p0; s_pc[1] = p1; s_pc[2] = p2;
    s_resp = resp; s_tag = tag; s_data = data;
  endtask

  task automatic rand_stim();
    logic [31:0] r;
    logic [3:0]  t;
    s_rst = ($urandom_range(0, 199) == 0);
    s_en  = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) begin
      r = $urandom();
      s_pc[i] = {r[31:16], 8'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), r[2:0]};
    end
    s_resp = (exp_load() && $urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    s_data = {$urandom(), $urandom()};
    s_tag  = 4'd0;
    if (ret_pending && ret_delay == 0) begin
      s_tag  = ret_tag;
      s_data = ret_data;
    end else if ($urandom_range(0, 4) == 0) begin
      t = 4'($urandom_range(1, 15));
      if (!(ret_pending && t == ret_tag)) s_tag = t;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      a_v[i] = 1'b0; a_t[i] = 8'd0; a_d[i] = 64'd0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      set_d(1, 3'b000, 0, 0, 0, 0, 0, 0); step();
      chk("rst_cmd", o_cmd, 0); chk("rst_wr", o_wr, 0); chk("rst_busy", o_busy, 0);
    end
    // single miss with two rejected responses
    set_d(0, 3'b001, 32'h1000, 0, 0, 0, 0, 0); step(); chk("A_cmd", o_cmd, 0); chk("A_fv", o_fv, 0);
    step(); chk("B_cmd", o_cmd, 1); chk("B_addr", o_addr, 32'h1000);
    step(); chk("C_cmd", o_cmd, 1);
    s_resp = 4'd3; step(); chk("D_cmd", o_cmd, 1);
    s_resp = 4'd0; step(); chk("E_cmd", o_cmd, 0); chk("E_busy", o_busy, 1);
    s_tag = 4'd3; s_data = 64'h0123456789ABCDEF; step();
    chk("F_wr", o_wr, 1); chk("F_idx", o_widx, 0); chk("F_tag", o_wtag, 8'h10);
    chk("F_data", o_wdata, 64'h0123456789ABCDEF);
    s_tag = 4'd0; step(); chk("G_fv", o_fv, 3'b001); chk("G_busy", o_busy, 0);
    // two younger slots miss; oldest missing first, then the other 2 cycles after fill
    set_d(0, 3'b111, 32'h1000, 32'h2008, 32'h3010, 0, 0, 0); step();
    chk("H_cmd", o_cmd, 0); chk("H_fv", o_fv, 3'b001);
    s_resp = 4'd5; step(); chk("I_cmd", o_cmd, 1); chk("I_addr", o_addr, 32'h2008);
    s_resp = 4'd0; s_tag = 4'd4; step(); chk("J_wr", o_wr, 0); chk("J_busy", o_busy, 1);
    s_tag = 4'd5; s_data = 64'hAAAA55550000FFFF; step();
    chk("K_wr", o_wr, 1); chk("K_idx", o_widx, 1); chk("K_tag", o_wtag, 8'h20);
    step(); chk("L_wr", o_wr, 0); chk("L_cmd", o_cmd, 0);
    s_tag = 4'd0; s_resp = 4'd2; step(); chk("M_cmd", o_cmd, 1); chk("M_addr", o_addr, 32'h3010);
    // reset while waiting for tag 2, then tag 2 arrives late
    set_d(1, 3'b000, 0, 0, 0, 0, 0, 0); step(); chk("N_wr", o_wr, 0);
    set_d(0, 3'b000, 0, 0, 0, 0, 2, 64'h1); step(); chk("O_wr", o_wr, 0); chk("O_busy", o_busy, 0);
    step(); chk("P_wr", o_wr, 0); chk("P_cmd", o_cmd, 0);
    // top-of-address-space line: prefetch would wrap to 0
    set_d(0, 3'b001, 32'hFFFFFFF8, 0, 0, 0, 0, 0); step(); chk("Q_cmd", o_cmd, 0);
    s_resp = 4'd7; step(); chk("R_cmd", o_cmd, 1); chk("R_addr", o_addr, 32'hFFFFFFF8);
    s_resp = 4'd0; s_tag = 4'd7; s_data = 64'h7; step();
    chk("S_wr", o_wr, 1); chk("S_idx", o_widx, 31); chk("S_tag", o_wtag, 8'hFF);
    set_d(0, 3'b000, 0, 0, 0, 8, 0, 0); step();
`ifdef ICACHE_PREFETCH_EN
    chk("T_cmd", o_cmd, 1); chk("T_addr", o_addr, 32'h0);
`else
    chk("T_cmd", o_cmd, 0);
`endif
    s_resp = 4'd0; s_tag = 4'd8; s_data = 64'h8; step();
`ifdef ICACHE_PREFETCH_EN
    chk("U_wr", o_wr, 1); chk("U_idx", o_widx, 0); chk("U_tag", o_wtag, 8'h00);
`else
    chk("U_wr", o_wr, 0); chk("U_cmd", o_cmd, 0);
`endif
    s_tag = 4'd0; step(); chk("V_busy", o_busy, 0);
    // randomized traffic against the reference
    for (int n = 0; n < 4000; n++) begin
      rand_stim();
      step();
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
Controller for the 32-entry direct-mapped, 3-read/1-write instruction cache memory. It drives that array's three read index/tag ports from the three fetch PCs and returns per-slot hit data to fetch. It also detects misses, issues one line load at a time to instruction memory, tracks the memory response tag, and sequences the single write port to fill the returned line.

Parameters:
NUM_PORTS, 3, fetch slots; slot 0 is oldest in program order
IDX_BITS, 5, cache index width, addr[7:3]
TAG_BITS, 8, cache tag width, addr[15:8]
MEM_TAG_BITS, 4, memory transaction tag width; tag 0 means none/rejected

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
fetch_en  in  NUM_PORTS  slot i requests the instruction at fetch_pc[i]
fetch_pc  in  NUM_PORTS x 32  byte PCs
fetch_data  out  NUM_PORTS x 64  line containing fetch_pc[i]
fetch_valid  out  NUM_PORTS  fetch_en[i] && hit
cm_rd_idx  out  NUM_PORTS x IDX_BITS  to cache memory read index
cm_rd_tag  out  NUM_PORTS x TAG_BITS  to cache memory read tag
cm_rd_data  in  NUM_PORTS x 64  from cache memory
cm_rd_valid  in  NUM_PORTS  from cache memory (valid && tag match)
cm_wr_en  out  1  fill write enable
cm_wr_idx  out  IDX_BITS  fill index
cm_wr_tag  out  TAG_BITS  fill tag
cm_wr_data  out  64  fill data
mem_command  out  2  0=NONE, 1=LOAD
mem_addr  out  32  line address, bits [2:0]=0
mem_response  in  MEM_TAG_BITS  nonzero = load accepted with this tag
mem_data  in  64  returned line
mem_tag  in  MEM_TAG_BITS  tag of mem_data; 0 = nothing returned
busy  out  1  state != IDLE

Behaviour:
- Read path, combinational: cm_rd_idx[i]=fetch_pc[i][7:3]; cm_rd_tag[i]=fetch_pc[i][15:8]; fetch_data[i]=cm_rd_data[i]; fetch_valid[i]=fetch_en[i]&&cm_rd_valid[i].
- Miss select: the lowest i with fetch_en[i]&&!cm_rd_valid[i]. The miss line address is {fetch_pc[i][31:3],3'b0}.
- FSM states: IDLE, REQ, WAIT. Registers: req_addr[31:0], pend_tag[MEM_TAG_BITS-1:0].
- IDLE: if a miss exists, latch req_addr and go to REQ. Otherwise stay in IDLE. mem_command=NONE.
- REQ: mem_command=LOAD, mem_addr=req_addr. req_addr stays fixed even if fetch_pc changes.
  - mem_response!=0: latch pend_tag=mem_response and go to WAIT.
  - mem_response==0: stay in REQ and retry next cycle.
- WAIT: mem_command=NONE.
  - When mem_tag==pend_tag (and pend_tag!=0), drive cm_wr_en=1 combinationally that cycle with cm_wr_idx=req_addr[7:3], cm_wr_tag=req_addr[15:8], cm_wr_data=mem_data.
  - Then clear pend_tag and go to IDLE; the array captures the write at that posedge.
  - Other mem_tag values are ignored.
- One outstanding demand load maximum. The fill is written even if fetch was redirected.
- Same-cycle events:
  - A fill and a read of the same index in one cycle: the read sees old contents; the hit appears the next cycle.
  - A miss seen in the fill cycle is not accepted; IDLE re-evaluates it the following cycle, so there are 2 cycles from fill to new request.
- Latency: a miss detected in cycle t has LOAD asserted in cycle t+1. The hit returns the cycle after the fill.
- Reset: state=IDLE, req_addr=0, pend_tag=0, mem_command=NONE, cm_wr_en=0. Reset mid-REQ or mid-WAIT abandons the transaction; a late mem_tag is never written.
- cm_wr_en is 0 in every state except the WAIT match cycle.

Optional Feature:
ICACHE_PREFETCH_EN.
- With the macro defined: after each demand fill, the FSM enters PF_REQ (LOAD of req_addr+8, 32-bit wrap) and then PF_WAIT.
  - The returned line is written exactly like a demand fill, then the FSM returns to IDLE.
  - A demand miss arriving during prefetch waits until IDLE.
  - Reset during PF_* behaves as in WAIT.
- Without the macro: no PF states exist, and WAIT always returns to IDLE.

Test Plan:
- Reset, all fetch_en=0 -> mem_command=0, cm_wr_en=0, busy=0 every cycle.
- fetch_en=3'b001, pc0=0x1000, cm_rd_valid=0 -> next cycle LOAD, mem_addr=0x1000. With mem_response=0 for 2 cycles then 3 -> LOAD held 3 cycles. mem_tag=3 later -> cm_wr_en=1, idx=0, tag=0x10, data=mem_data. fetch_valid[0]=1 the cycle after.
- Slots 1 and 2 miss (pc1=0x2008, pc2=0x3010), slot 0 hits -> first LOAD 0x2008 only. 0x3010 is requested 2 cycles after that fill.
- In WAIT with pend_tag=5: mem_tag=4 -> no write. mem_tag=5 -> exactly one write cycle.
- Reset asserted in WAIT (pend_tag=2), then mem_tag=2 -> no cm_wr_en; state IDLE.
- ICACHE_PREFETCH_EN: demand fill of 0xFFFFFFF8 -> next LOAD 0x00000000, filled to idx 0. Without the macro -> no second LOAD.
